// File: rtl/pwm_duty_serializer.sv
// Serialises duty words MSB-first to a downstream PWM shift register.
// Define SLEW_LIMIT_EN to step toward each target by at most MAX_STEP per frame.
module pwm_duty_serializer #(
    parameter int DATA_W     = 8,
    parameter int GAP_CYCLES = 1,
    parameter int MAX_STEP   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    output logic              shift_en,
    output logic              data_out,
    output logic              frame_done
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYCLES - 1);

    if (GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_gap_chk
        $error("GAP_CYCLES must be within 1..15");
    end
    if (MAX_STEP < 1 || MAX_STEP > (2 ** DATA_W) - 1) begin : g_step_chk
        $error("MAX_STEP must be within 1..2^DATA_W-1");
    end
    if (DATA_W < 2) begin : g_width_chk
        $error("DATA_W must be at least 2");
    end

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [DATA_W-1:0] target;
    logic [DATA_W-1:0] target_n;
    logic [DATA_W-1:0] last_sent;
    logic [DATA_W-1:0] last_n;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_n;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_n;
    logic [3:0]        gap_cnt;
    logic [3:0]        gap_n;
    logic              shift_n;
    logic              data_n;
    logic              done_n;
    logic              ready_n;
    logic              start;
    logic [DATA_W-1:0] start_word;
    logic [DATA_W-1:0] word;

`ifdef SLEW_LIMIT_EN
    localparam logic [DATA_W:0] STEP = (DATA_W + 1)'(MAX_STEP);

    logic [DATA_W-1:0] word_n;

    // One extra bit of headroom keeps cur+STEP from wrapping.
    function automatic logic [DATA_W-1:0] slew(
        input logic [DATA_W-1:0] tgt,
        input logic [DATA_W-1:0] cur
    );
        logic [DATA_W:0] t;
        logic [DATA_W:0] c;
        logic [DATA_W:0] r;
        t = {1'b0, tgt};
        c = {1'b0, cur};
        r = t;
        if (t > c + STEP) begin
            r = c + STEP;
        end else if (c > t + STEP) begin
            r = c - STEP;
        end
        return r[DATA_W-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word <= '0;
        end else begin
            word <= word_n;
        end
    end
`else
    assign word = target;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            target     <= '0;
            last_sent  <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            shift_en   <= 1'b0;
            data_out   <= 1'b0;
            frame_done <= 1'b0;
            duty_ready <= 1'b1;
        end else begin
            state      <= state_n;
            target     <= target_n;
            last_sent  <= last_n;
            shreg      <= shreg_n;
            bit_cnt    <= bit_n;
            gap_cnt    <= gap_n;
            shift_en   <= shift_n;
            data_out   <= data_n;
            frame_done <= done_n;
            duty_ready <= ready_n;
        end
    end

    always_comb begin
        state_n    = state;
        target_n   = target;
        last_n     = last_sent;
        shreg_n    = shreg;
        bit_n      = bit_cnt;
        gap_n      = gap_cnt;
        shift_n    = 1'b0;
        data_n     = 1'b0;
        done_n     = 1'b0;
        ready_n    = 1'b0;
        start      = 1'b0;
        start_word = target;
`ifdef SLEW_LIMIT_EN
        word_n     = word;
`endif

        unique case (state)
            IDLE: begin
                ready_n = 1'b1;
                if (duty_valid) begin
                    target_n = duty_in;
                    start    = 1'b1;
`ifdef SLEW_LIMIT_EN
                    start_word = slew(duty_in, last_sent);
`else
                    start_word = duty_in;
`endif
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    state_n = GAP;
                    done_n  = 1'b1;
                    last_n  = word;
                    gap_n   = GAP_LAST;
                end else begin
                    shift_n = 1'b1;
                    data_n  = shreg[DATA_W-1];
                    shreg_n = {shreg[DATA_W-2:0], 1'b0};
                    bit_n   = bit_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt != 4'd0) begin
                    gap_n = gap_cnt - 4'd1;
                end else begin
`ifdef SLEW_LIMIT_EN
                    // last_sent already equals word here.
                    if (word != target) begin
                        start      = 1'b1;
                        start_word = slew(target, last_sent);
                    end else begin
                        state_n = IDLE;
                        ready_n = 1'b1;
                    end
`else
                    state_n = IDLE;
                    ready_n = 1'b1;
`endif
                end
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase

        if (start) begin
            state_n = SHIFT;
            ready_n = 1'b0;
            shift_n = 1'b1;
            data_n  = start_word[DATA_W-1];
            shreg_n = {start_word[DATA_W-2:0], 1'b0};
            bit_n   = '0;
`ifdef SLEW_LIMIT_EN
            word_n  = start_word;
`endif
        end
    end

endmodule

// File: doc/pwm_duty_serializer.md
PWM_DUTY_SERIALIZER -- requirements
Module: pwm_duty_serializer

Interface
REQ-001 Parameter DATA_W, default 8: duty word width and serial frame length in bits.
REQ-002 Parameter GAP_CYCLES, default 1, legal range 1..15: idle cycles forced between consecutive frames.
REQ-003 Parameter MAX_STEP, default 16, legal range 1..2^DATA_W-1: largest duty change per frame, used only when SLEW_LIMIT_EN is defined.
REQ-004 Port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port duty_in, input, DATA_W bits: requested duty value.
REQ-007 Port duty_valid, input, 1 bit: duty_in is valid this cycle.
REQ-008 Port duty_ready, output, 1 bit: block accepts a new duty value this cycle.
REQ-009 Port shift_en, output, 1 bit: serial frame strobe to the downstream PWM shift register.
REQ-010 Port data_out, output, 1 bit: serial duty bit, meaningful only while shift_en=1.
REQ-011 Port frame_done, output, 1 bit: one-cycle pulse after the last bit of each frame.

Function
REQ-012 All outputs are registered; none is combinationally driven by duty_in or duty_valid.
REQ-013 FSM states: IDLE, SHIFT, GAP.
REQ-014 IDLE: duty_ready=1, shift_en=0, data_out=0.
REQ-015 Acceptance occurs on a cycle with duty_valid=1 and duty_ready=1; duty_in is captured into a target register; the FSM moves to SHIFT.
REQ-016 duty_valid while duty_ready=0 is ignored; no value is captured.
REQ-017 Latency: shift_en rises on the first cycle after acceptance.
REQ-018 SHIFT: shift_en=1 for exactly DATA_W consecutive cycles; data_out carries the frame word MSB first, one bit per cycle.
REQ-019 At the end of SHIFT, shift_en drops to 0 and frame_done=1 for exactly one cycle, coincident with the first GAP cycle.
REQ-020 GAP: lasts GAP_CYCLES cycles with shift_en=0 and duty_ready=0.
REQ-021 At the end of GAP, the FSM returns to IDLE if the last frame word equals the target; otherwise it starts a new SHIFT frame (SLEW_LIMIT_EN only).
REQ-022 Register last_sent holds the word of the most recent completed frame and updates when frame_done is asserted.
REQ-023 Minimum accept-to-accept spacing: 1+DATA_W+GAP_CYCLES cycles for a single-frame update.
REQ-024 A new value equal to last_sent still produces one full frame.

Reset
REQ-025 While rst_n=0 at a clock edge, the next state is IDLE and all registers clear.
REQ-026 Reset values: shift_en=0, data_out=0, frame_done=0, duty_ready=1, target=0, last_sent=0, bit counter=0, gap counter=0.
REQ-027 Reset asserted mid-frame aborts the frame: shift_en=0 on the cycle after the edge, no frame_done pulse, last_sent=0.

Configuration
REQ-028 Macro SLEW_LIMIT_EN, when defined, enables slew limiting: each frame word = target if |target-last_sent| <= MAX_STEP, else last_sent+MAX_STEP (target above) or last_sent-MAX_STEP (target below).
REQ-029 With SLEW_LIMIT_EN, frames repeat back-to-back, each separated by GAP, until a frame word equals target; duty_ready stays 0 throughout.
REQ-030 Slew arithmetic uses DATA_W+1 bits and never wraps below 0 or above 2^DATA_W-1.
REQ-031 Without SLEW_LIMIT_EN, every accepted value produces exactly one frame carrying the target word, and the slew datapath is not synthesised.

Verification
REQ-032 Reset released, duty_in=8'hC0 accepted -> next 8 cycles shift_en=1, data_out=1,1,0,0,0,0,0,0; frame_done on cycle 9; duty_ready=1 on cycle 10 (GAP_CYCLES=1).
REQ-033 duty_valid=1 with 8'h55 held continuously -> frames start every 10 cycles; no value captured during SHIFT or GAP.
REQ-034 rst_n=0 on the 4th bit of a 8'hFF frame -> shift_en=0 the following cycle, no frame_done, duty_ready=1, last_sent=0.
REQ-035 SLEW_LIMIT_EN, MAX_STEP=16, last_sent=0, request 8'h30 -> three frames 8'h10, 8'h20, 8'h30; duty_ready returns to 1 only after the third.
REQ-036 SLEW_LIMIT_EN, last_sent=8'hF8, request 8'h00 -> frames 8'hE8, 8'hD8, ... down to 8'h08, then a final 8'h00; never any underflow.
REQ-037 Without SLEW_LIMIT_EN, last_sent=8'h00, request 8'hFF -> one frame of 8'hFF.
